// File: rtl/perf_pkg.sv
// perf_pkg: shared types for the performance-counter controller.
//   perf_cnt_t        : {ovf, count} word at the default counter width
//   perf_cfg_t        : per-counter configuration {sel, en} at the default event count
//   perf_dump_state_t : dump sequencer states
// The top level is parameterized. It builds its own storage at the
// configured widths. The packed types below describe the default build.
package perf_pkg;

   localparam int PERF_EVENT_NUM = 32;
   localparam int PERF_CNT_NUM   = 8;
   localparam int PERF_CNT_WIDTH = 48;
   localparam int PERF_SEL_W     = $clog2(PERF_EVENT_NUM) + 1;

   typedef logic [PERF_CNT_WIDTH:0] perf_cnt_t;   // {ovf, count}

   typedef struct packed {
      logic [PERF_SEL_W-1:0] sel;
      logic                  en;
   } perf_cfg_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } perf_dump_state_t;

endpackage

// File: rtl/perf_counter_slot.sv
// perf_counter_slot: one programmable event counter.
// Ports:
//   clk, rst             : clock, async active-high reset
//   event_i[EVENT_NUM]   : event strobes
//   cfg_we               : config write aimed at this slot (loads sel/en, clears count/ovf)
//   cfg_sel, cfg_en      : new event select / enable
//   cnt_o[CNT_WIDTH+1]   : {ovf, count}
module perf_counter_slot
   import perf_pkg::*;
#(
   parameter int EVENT_NUM = PERF_EVENT_NUM,
   parameter int CNT_WIDTH = PERF_CNT_WIDTH
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic [EVENT_NUM-1:0]         event_i,
   input  logic                         cfg_we,
   input  logic [$clog2(EVENT_NUM):0]   cfg_sel,
   input  logic                         cfg_en,
   output logic [CNT_WIDTH:0]           cnt_o
);

   localparam int SEL_W = $clog2(EVENT_NUM) + 1;

   logic [SEL_W-1:0]     sel;
   logic                 en;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 ovf;
   logic                 hit;

   // Select compares against every legal event index, so selects at or
   // above EVENT_NUM simply never match.
   always_comb begin
      hit = 1'b0;
      for (int e = 0; e < EVENT_NUM; e++) begin
         if (en && (sel == SEL_W'(e)) && event_i[e]) hit = 1'b1;
      end
   end

   // A config write wins over a same-cycle increment; that event is lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel <= '0;
         en  <= 1'b0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (cfg_we) begin
         sel <= cfg_sel;
         en  <= cfg_en;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (hit) begin
         cnt <= cnt + 1'b1;
         if (&cnt) ovf <= 1'b1;   // sticky on wrap
      end
   end

   assign cnt_o = {ovf, cnt};

endmodule

// File: rtl/perf_event_ctrl.sv
// perf_event_ctrl: pool of programmable event counters with a snapshot dump
// sequencer feeding a valid/ready stream.
// Ports:
//   clk, rst                     : clock, async active-high reset
//   event_i[EVENT_NUM]           : single-cycle event strobes
//   cfg_we/cfg_idx/cfg_sel/cfg_en: counter configuration write
//   rd_idx -> rd_data            : registered live read {ovf, count}
//   dump_req                     : manual dump request (dropped while busy)
//   dump_valid/dump_ready        : dump beat handshake
//   dump_idx/dump_data           : beat index and snapshot {ovf, count}
//   dump_busy                    : dump sequence in progress
module perf_event_ctrl
   import perf_pkg::*;
#(
   parameter int EVENT_NUM   = PERF_EVENT_NUM,
   parameter int CNT_NUM     = PERF_CNT_NUM,
   parameter int CNT_WIDTH   = PERF_CNT_WIDTH,
   parameter int DUMP_PERIOD = 4096
)(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [EVENT_NUM-1:0]        event_i,
   input  logic                        cfg_we,
   input  logic [$clog2(CNT_NUM)-1:0]  cfg_idx,
   input  logic [$clog2(EVENT_NUM):0]  cfg_sel,
   input  logic                        cfg_en,
   input  logic [$clog2(CNT_NUM)-1:0]  rd_idx,
   output logic [CNT_WIDTH:0]          rd_data,
   input  logic                        dump_req,
   output logic                        dump_valid,
   input  logic                        dump_ready,
   output logic [$clog2(CNT_NUM)-1:0]  dump_idx,
   output logic [CNT_WIDTH:0]          dump_data,
   output logic                        dump_busy
);

   localparam int IDX_W = $clog2(CNT_NUM);
   localparam int PER_W = (DUMP_PERIOD > 1) ? $clog2(DUMP_PERIOD) : 1;
   localparam logic [PER_W-1:0] PER_LAST = PER_W'((DUMP_PERIOD > 0) ? DUMP_PERIOD - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CNT_NUM - 1);

   logic [CNT_NUM-1:0][CNT_WIDTH:0] live;
   logic [CNT_NUM-1:0][CNT_WIDTH:0] shadow;

   perf_dump_state_t state, state_n;
   logic [IDX_W-1:0] idx_n;
   logic             take;
   logic [PER_W-1:0] per;
   logic             per_wrap;
   logic             pend;

   // ---------------- counter pool ----------------
   for (genvar i = 0; i < CNT_NUM; i++) begin : g_slot
      perf_counter_slot #(
         .EVENT_NUM (EVENT_NUM),
         .CNT_WIDTH (CNT_WIDTH)
      ) u_slot (
         .clk     (clk),
         .rst     (rst),
         .event_i (event_i),
         .cfg_we  (cfg_we && (cfg_idx == IDX_W'(i))),
         .cfg_sel (cfg_sel),
         .cfg_en  (cfg_en),
         .cnt_o   (live[i])
      );
   end

   // ---------------- live read ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data <= '0;
      else     rd_data <= live[rd_idx];
   end

   // ---------------- auto-dump timer ----------------
   // A zero period leaves the timer idle and never raises a request.
   assign per_wrap = (DUMP_PERIOD != 0) && (per == PER_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         per  <= '0;
         pend <= 1'b0;
      end else begin
         per  <= per_wrap ? '0 : per + 1'b1;
         // One-deep: extra wraps merge; a wrap in the consuming cycle re-arms.
         pend <= per_wrap | (pend & ~take);
      end
   end

   // ---------------- dump sequencer ----------------
   always_comb begin
      state_n = state;
      idx_n   = dump_idx;
      take    = 1'b0;
      case (state)
         IDLE: begin
            if (dump_req || pend) begin
               state_n = SEND;
               idx_n   = '0;
               take    = 1'b1;
            end
         end
         SEND: begin
            if (dump_ready) begin
               if (dump_idx == IDX_LAST) state_n = IDLE;
               else                      idx_n   = dump_idx + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         dump_idx <= '0;
      end else begin
         state    <= state_n;
         dump_idx <= idx_n;
      end
   end

   // Snapshot takes the pre-edge live values, so the request cycle's
   // increments are not included.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       shadow <= '0;
      else if (take) shadow <= live;
   end

   assign dump_valid = (state == SEND);
   assign dump_busy  = (state == SEND);
   assign dump_data  = shadow[dump_idx];

endmodule

// File: tb/tb_perf_event_ctrl.sv
// Self-checking bench for perf_event_ctrl (small build: CNT_WIDTH 4, DUMP_PERIOD 16).
// A behavioural model of counters, snapshot and dump stream is advanced once
// per clock and compared with the DUT outputs on every falling edge.
module tb_perf_event_ctrl;

   localparam int EN = 32;
   localparam int CN = 8;
   localparam int CW = 4;
   localparam int DP = 16;
   localparam int IW = 3;
   localparam int SW = 6;
   localparam int DW = CW + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [EN-1:0] event_i;
   logic          cfg_we;
   logic [IW-1:0] cfg_idx;
   logic [SW-1:0] cfg_sel;
   logic          cfg_en;
   logic [IW-1:0] rd_idx;
   logic [DW-1:0] rd_data;
   logic          dump_req;
   logic          dump_valid;
   logic          dump_ready;
   logic [IW-1:0] dump_idx;
   logic [DW-1:0] dump_data;
   logic          dump_busy;

   always #5 clk = ~clk;

   perf_event_ctrl #(
      .EVENT_NUM   (EN),
      .CNT_NUM     (CN),
      .CNT_WIDTH   (CW),
      .DUMP_PERIOD (DP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .event_i    (event_i),
      .cfg_we     (cfg_we),
      .cfg_idx    (cfg_idx),
      .cfg_sel    (cfg_sel),
      .cfg_en     (cfg_en),
      .rd_idx     (rd_idx),
      .rd_data    (rd_data),
      .dump_req   (dump_req),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_idx   (dump_idx),
      .dump_data  (dump_data),
      .dump_busy  (dump_busy)
   );

   // ---------------- reference model ----------------
   int m_sel [CN];
   bit m_en  [CN];
   int m_cnt [CN];
   bit m_ovf [CN];
   int m_shadow [CN];
   bit m_send;
   int m_idx;
   int m_per;
   bit m_pend;
   int m_rd;

   int passed = 0;
   int total  = 0;

   bit capture = 1'b0;
   int beat_idx[$];
   int beat_data[$];

   function automatic int word(int i);
      return (m_ovf[i] ? (1 << CW) : 0) + m_cnt[i];
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < CN; i++) begin
         m_sel[i] = 0; m_en[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_shadow[i] = 0;
      end
      m_send = 0; m_idx = 0; m_per = 0; m_pend = 0; m_rd = 0;
   endfunction

   // Advances the model across one rising edge using the current inputs.
   function automatic void model_step();
      int  snap [CN];
      int  nxt_rd;
      bit  wrap;
      bit  go;
      nxt_rd = word(int'(rd_idx));
      for (int i = 0; i < CN; i++) snap[i] = word(i);
      wrap = (m_per == DP - 1);
      go   = !m_send && (dump_req || m_pend);
      if (go) begin
         m_send = 1; m_idx = 0; m_shadow = snap;
      end else if (m_send && dump_ready) begin
         if (m_idx == CN - 1) m_send = 0;
         else                 m_idx++;
      end
      m_pend = wrap || (m_pend && !go);
      m_per  = wrap ? 0 : m_per + 1;
      for (int i = 0; i < CN; i++) begin
         if (cfg_we && int'(cfg_idx) == i) begin
            m_sel[i] = int'(cfg_sel); m_en[i] = cfg_en; m_cnt[i] = 0; m_ovf[i] = 0;
         end else if (m_en[i] && m_sel[i] < EN && event_i[m_sel[i]]) begin
            m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
            if (m_cnt[i] == 0) m_ovf[i] = 1;
         end
      end
      m_rd = nxt_rd;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_outputs();
      chk("dump_valid", 64'(dump_valid), 64'(m_send));
      chk("dump_busy",  64'(dump_busy),  64'(m_send));
      chk("rd_data",    64'(rd_data),    64'(m_rd));
      if (m_send) begin
         chk("dump_idx",  64'(dump_idx),  64'(m_idx));
         chk("dump_data", 64'(dump_data), 64'(m_shadow[m_idx]));
      end
   endtask

   task automatic idle_inputs();
      event_i  = '0;
      cfg_we   = 1'b0;
      cfg_idx  = '0;
      cfg_sel  = '0;
      cfg_en   = 1'b0;
      dump_req = 1'b0;
   endtask

   // Called at a falling edge with inputs set; returns at the next falling edge.
   task automatic tick();
      if (capture && dump_valid && dump_ready && beat_idx.size() < CN) begin
         beat_idx.push_back(int'(dump_idx));
         beat_data.push_back(int'(dump_data));
      end
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic cfg(input int idx, input int sel, input bit en);
      idle_inputs();
      cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_sel = SW'(sel); cfg_en = en;
      tick();
      idle_inputs();
   endtask

   task automatic read(input int idx, output int val);
      idle_inputs();
      rd_idx = IW'(idx);
      tick();
      val = int'(rd_data);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("rst_valid_drop", 64'(dump_valid), 64'd0);
      chk("rst_busy_drop",  64'(dump_busy),  64'd0);
      model_reset();
      @(negedge clk);
      check_outputs();
      chk("rst_dump_idx",  64'(dump_idx),  64'd0);
      chk("rst_dump_data", 64'(dump_data), 64'd0);
      rst = 1'b0;
   endtask

   int v;
   int n;
   int first_busy;

   initial begin
      rst = 1'b1;
      idle_inputs();
      rd_idx = '0;
      dump_ready = 1'b0;
      model_reset();
      @(negedge clk);
      check_outputs();
      chk("reset_dump_idx",  64'(dump_idx),  64'd0);
      chk("reset_dump_data", 64'(dump_data), 64'd0);
      rst = 1'b0;
      dump_ready = 1'b1;

      // Count and read.
      cfg(2, 5, 1);
      for (int k = 0; k < 10; k++) begin
         event_i = '0; event_i[5] = 1'b1; tick();
      end
      read(2, v); chk("count10", 64'(v), 64'd10);
      read(0, v); chk("other_zero", 64'(v), 64'd0);

      // Wrap to 1 with sticky overflow, then a cfg write clears both.
      cfg(3, 7, 1);
      for (int k = 0; k < 17; k++) begin
         event_i = '0; event_i[7] = 1'b1; tick();
      end
      read(3, v); chk("wrap_ovf", 64'(v), 64'h11);
      cfg(3, 7, 1);
      read(3, v); chk("wrap_clear", 64'(v), 64'd0);

      // Config write beats a same-cycle increment.
      cfg(4, 9, 1);
      event_i = '0; event_i[9] = 1'b1; tick();
      idle_inputs();
      event_i[9] = 1'b1;
      cfg_we = 1'b1; cfg_idx = 3'd4; cfg_sel = 6'd9; cfg_en = 1'b1;
      tick();
      read(4, v); chk("write_beats_inc", 64'(v), 64'd0);

      // Out-of-range select never counts.
      cfg(5, EN, 1);
      for (int k = 0; k < 20; k++) begin
         event_i = '1; tick();
      end
      read(5, v); chk("oor_sel", 64'(v), 64'd0);

      // Preload counters with 1..8.
      for (int i = 0; i < CN; i++) cfg(i, 10 + i, 1);
      for (int k = 0; k < CN; k++) begin
         idle_inputs();
         for (int i = 0; i < CN; i++) if (i + 1 > k) event_i[10 + i] = 1'b1;
         tick();
      end
      idle_inputs();
      n = 0;
      while (m_send && n < 50) begin tick(); n++; end
      chk("idle_wait", 64'(m_send), 64'd0);

      // Stalled dump with live events and a dropped second request.
      dump_req = 1'b1;
      tick();
      dump_req = 1'b0;
      capture = 1'b1;
      n = 0;
      while (beat_idx.size() < CN && n < 60) begin
         idle_inputs();
         dump_ready = (n % 3) != 1;
         event_i = EN'($urandom);
         if (n == 3) dump_req = 1'b1;
         tick();
         n++;
      end
      capture = 1'b0;
      idle_inputs();
      dump_ready = 1'b1;
      chk("beat_count", 64'(beat_idx.size()), 64'(CN));
      for (int k = 0; k < CN; k++) begin
         if (k < beat_idx.size()) begin
            chk("beat_idx",  64'(beat_idx[k]),  64'(k));
            chk("beat_data", 64'(beat_data[k]), 64'(k + 1));
         end
      end

      // Auto-dump: stalled for 40 cycles, then the merged request follows.
      @(negedge clk);
      do_reset();
      dump_ready = 1'b0;
      first_busy = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (dump_busy && first_busy < 0) first_busy = k;
      end
      chk("auto_first_start", 64'(first_busy), 64'd17);
      chk("auto_still_beat0", 64'(dump_idx), 64'd0);
      dump_ready = 1'b1;
      n = 0;
      while (dump_busy && n < 20) begin tick(); n++; end
      chk("auto_done", 64'(dump_busy), 64'd0);
      tick();
      chk("auto_merged_start", 64'(dump_busy), 64'd1);

      // Reset in the middle of a dump.
      for (int i = 0; i < CN; i++) cfg(i, i, 1);
      event_i = '1; tick(); tick();
      idle_inputs();
      n = 0;
      while (dump_busy && n < 20) begin tick(); n++; end
      dump_req = 1'b1;
      tick();
      dump_req = 1'b0;
      n = 0;
      while (!(dump_valid && dump_idx == 3'd3) && n < 20) begin tick(); n++; end
      chk("reach_beat3", 64'(dump_idx), 64'd3);
      #2;
      do_reset();
      for (int i = 0; i < CN; i++) begin
         read(i, v); chk("rst_counter", 64'(v), 64'd0);
      end

      // Random traffic.
      for (int k = 0; k < 400; k++) begin
         idle_inputs();
         event_i    = EN'($urandom);
         cfg_we     = ($urandom_range(0, 7) == 0);
         cfg_idx    = IW'($urandom_range(0, CN - 1));
         cfg_sel    = SW'($urandom_range(0, EN + 3));
         cfg_en     = ($urandom_range(0, 3) != 0);
         dump_req   = ($urandom_range(0, 15) == 0);
         dump_ready = ($urandom_range(0, 2) != 0);
         rd_idx     = IW'($urandom_range(0, CN - 1));
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/perf_event_ctrl.md
# perf_event_ctrl

Shared hardware performance-counter controller. Maps a wide vector of single-cycle event strobes onto a small pool of programmable counters, and sequences periodic or on-demand dumps of a coherent counter snapshot over a valid/ready stream into the difftest event logger. It sits beside the core's per-module `PERF` points and replaces ad-hoc one-counter-per-event instances where counter area matters.

## Interface
Parameters:
- `EVENT_NUM`, 32: number of event strobe inputs.
- `CNT_NUM`, 8: number of programmable counters (power of two).
- `CNT_WIDTH`, 48: counter width.
- `DUMP_PERIOD`, 4096: cycles between automatic dumps; 0 disables auto-dump.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `event_i`, in, EVENT_NUM: event strobes, one count per high cycle.
- `cfg_we`, in, 1: config write strobe.
- `cfg_idx`, in, $clog2(CNT_NUM): counter being configured.
- `cfg_sel`, in, $clog2(EVENT_NUM)+1: event select. Values ≥ EVENT_NUM never fire.
- `cfg_en`, in, 1: counter enable.
- `rd_idx`, in, $clog2(CNT_NUM): live read index.
- `rd_data`, out, CNT_WIDTH+1: {ovf, count} of `rd_idx`, registered.
- `dump_req`, in, 1: manual dump request pulse.
- `dump_valid`, out, 1: dump beat valid.
- `dump_ready`, in, 1: downstream accept.
- `dump_idx`, out, $clog2(CNT_NUM): counter index of current beat.
- `dump_data`, out, CNT_WIDTH+1: {ovf, count} snapshot of `dump_idx`.
- `dump_busy`, out, 1: dump sequence in progress.

## Operation
- Per counter i:
  - State: `sel[i]`, `en[i]`, `cnt[i]`, `ovf[i]`.
  - Each cycle, if `en[i] && sel[i] < EVENT_NUM && event_i[sel[i]]`, then `cnt[i] <= cnt[i]+1`.
  - The count wraps modulo 2^CNT_WIDTH. On wrap, `ovf[i]` sets and stays set (sticky).
  - Several counters may select the same event; each counts independently.
- Config write with `cfg_we`:
  - Loads `sel` and `en` for `cfg_idx`.
  - Clears `cnt` and `ovf` for `cfg_idx`.
  - The write has priority over an increment in the same cycle, so that cycle's event is lost.
- Dump FSM has two states, IDLE and SEND.
  - IDLE → SEND when a request is seen (`dump_req` or a pending auto request). On that edge, copy all `{ovf,cnt}` into a shadow array and set `dump_idx <= 0`.
  - The snapshot holds the pre-edge values, so it excludes any increment in the request cycle.
  - In SEND, `dump_valid = 1`. On `dump_valid && dump_ready`:
    - If `dump_idx == CNT_NUM-1`, go to IDLE.
    - Otherwise increment `dump_idx`.
  - `dump_data`, `dump_idx` and `dump_valid` stay stable while stalled.
  - `dump_busy = (state == SEND)`.
- Live counters keep counting during SEND. Config writes during SEND affect live state only, never the shadow.
- Manual `dump_req` during SEND is dropped.
- Auto-dump:
  - A period counter counts 0..DUMP_PERIOD-1 and wraps.
  - At the wrap it sets a 1-deep `pend` flag. Further wraps while `pend` is set are merged into it.
  - `pend` is consumed on the IDLE → SEND transition.
  - If `pend` and `dump_req` occur together, they produce a single dump.

## Timing
- Reset values:
  - All `cnt`, `ovf`, `sel`, `en` are 0.
  - Period counter is 0, `pend` is 0, state is IDLE.
  - Outputs: `dump_valid` 0, `dump_busy` 0, `dump_idx` 0, `dump_data` 0, `rd_data` 0.
- Reset mid-dump aborts immediately and drops the sequence. No partial beat survives.
- Event to count: an increment is visible in `cnt` the cycle after the strobe. `rd_data` has 1-cycle latency from `rd_idx`, so a strobe shows on `rd_data` two cycles later.
- `dump_req` at cycle t gives `dump_valid` high at t+1. With `dump_ready` tied high, a full dump takes CNT_NUM cycles and the FSM is back in IDLE at t+1+CNT_NUM.
- The earliest new dump can be accepted in the IDLE cycle right after the last beat.

## Structure
- Package `perf_pkg`:
  - `perf_cnt_t` (CNT_WIDTH+1 packed {ovf, count}).
  - `perf_cfg_t` {sel, en}.
  - Enum `perf_dump_state_t` {IDLE, SEND}.
- Sub-module `perf_counter_slot`: one counter's sel/en/cnt/ovf registers, increment and clear logic. Instantiate it CNT_NUM times with generate.
- The dump FSM, shadow array, period counter and read mux live in the top level.

## Test plan
- Counting and read: cfg idx 2, sel 5, en 1; pulse `event_i[5]` for 10 cycles → `rd_data` for idx 2 = 10, ovf 0. Other counters stay 0.
- Wrap: CNT_WIDTH=4 build, 17 events → count 1, ovf 1. Then a cfg write to the same idx → count 0, ovf 0.
- Write vs increment: cfg write in the same cycle as a selected event → count 0 afterwards. Out-of-range sel (EVENT_NUM) → count stays 0 under all events.
- Stalled dump:
  - Counters preloaded 1..8. `dump_req`, then `dump_ready` toggles 1-0-1 → 8 beats, idx 0..7, data 1..8.
  - Events keep firing mid-dump and do not change the beats.
  - A second `dump_req` mid-dump is ignored.
- Auto-dump: DUMP_PERIOD=16, `dump_ready`=0 for 40 cycles → exactly one dump starts at cycle 16. One more (the merged pend) starts right after the first completes.
- Reset mid-dump: assert `rst` at beat 3 → `dump_valid`/`dump_busy` drop immediately and all counters read 0.
